inst_fetch: RTL and testbench



---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/inst_fetch_fifo2.sv | 77 +++++++
 rtl/inst_fetch.sv | 121 ++++++++++++
 tb/tb_inst_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inst_fetch_pkg : shared widths and instruction field helpers      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package inst_fetch_pkg;

  localparam int unsigned INST_WIDTH_DEF      = 16;
  localparam int unsigned CODE_ADDR_WIDTH_DEF = 10;
  localparam int unsigned UTIL_ADDR_LSB       = 0;
  localparam int unsigned UTIL_ADDR_MSB       = 3;

  function automatic logic [UTIL_ADDR_MSB-UTIL_ADDR_LSB:0] utility_addr(
    input logic [INST_WIDTH_DEF-1:0] inst
  );
    return inst[UTIL_ADDR_MSB:UTIL_ADDR_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_fifo2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_fifo2 : 2-entry output FIFO; flush beats push, head shown   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fetch_fifo2
  import inst_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop, do_push;

  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) head_d = push_data_i;
          else                 tail_d = push_data_i;
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and push keeps occupancy; new data fills the freed slot.
          if (count_q == 2'd1) begin
            head_d = push_data_i;
          end else begin
            head_d = tail_q;
            tail_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign vld_o   = (count_q != 2'd0);
  assign head_o  = head_q;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inst_fetch : instruction memory + fetch PC feeding the decoder    |
// | Optional AXIS_CPU_FETCH_STATS_EN adds stall/instruction counters  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned CODE_ADDR_WIDTH = CODE_ADDR_WIDTH_DEF,
  parameter int unsigned INST_WIDTH      = INST_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prog_wr_en_i,
  input  logic [CODE_ADDR_WIDTH-1:0] prog_wr_addr_i,
  input  logic [INST_WIDTH-1:0]      prog_wr_data_i,
  input  logic                       run_i,
  input  logic                       redirect_vld_i,
  input  logic [CODE_ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [INST_WIDTH-1:0]      inst_o,
  output logic [CODE_ADDR_WIDTH-1:0] inst_pc_o,
  output logic                       inst_vld_o,
  input  logic                       inst_rdy_i,
  output logic [CODE_ADDR_WIDTH-1:0] fetch_pc_o
`ifdef AXIS_CPU_FETCH_STATS_EN
  ,
  output logic [31:0]                stall_cnt_o,
  output logic [31:0]                inst_cnt_o
`endif
);

  localparam int unsigned ENTRY_W = INST_WIDTH + CODE_ADDR_WIDTH;

  logic [INST_WIDTH-1:0]      mem_q [2**CODE_ADDR_WIDTH];
  logic [INST_WIDTH-1:0]      rd_data_q;
  logic [CODE_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CODE_ADDR_WIDTH-1:0] inflight_pc_q;
  logic                       inflight_q;

  logic                       fifo_vld;
  logic [ENTRY_W-1:0]         fifo_head;
  logic [1:0]                 fifo_count;
  logic                       pop;
  logic                       push;
  logic                       issue;
  logic [2:0]                 occupancy;

  assign pop       = fifo_vld && inst_rdy_i;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = run_i && !redirect_vld_i && (occupancy < 3'd2);
  // A redirect in the return cycle cancels the read that is landing.
  assign push      = inflight_q && !redirect_vld_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_vld_i) fetch_pc_d = redirect_pc_i;
    else if (issue)     fetch_pc_d = fetch_pc_q + CODE_ADDR_WIDTH'(1);
  end

  // Read-first block RAM: a same-address write returns the old word.
  always_ff @(posedge clk) begin
    if (prog_wr_en_i) mem_q[prog_wr_addr_i] <= prog_wr_data_i;
    if (issue)        rd_data_q <= mem_q[fetch_pc_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fetch_pc_q;
    end
  end

  fetch_fifo2 #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i({rd_data_q, inflight_pc_q}),
    .pop_i      (pop),
    .flush_i    (redirect_vld_i),
    .vld_o      (fifo_vld),
    .head_o     (fifo_head),
    .count_o    (fifo_count)
  );

  assign inst_o     = fifo_head[ENTRY_W-1:CODE_ADDR_WIDTH];
  assign inst_pc_o  = fifo_head[CODE_ADDR_WIDTH-1:0];
  assign inst_vld_o = fifo_vld;
  assign fetch_pc_o = fetch_pc_q;

`ifdef AXIS_CPU_FETCH_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] inst_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      if (fifo_vld && !inst_rdy_i && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pop && (inst_cnt_q != 32'hFFFF_FFFF))
        inst_cnt_q <= inst_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign inst_cnt_o  = inst_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_inst_fetch : self-checking bench for inst_fetch                |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_wr_en;
  logic [9:0]  prog_wr_addr;
  logic [15:0] prog_wr_data;
  logic        run;
  logic        redirect_vld;
  logic [9:0]  redirect_pc;
  logic [15:0] inst;
  logic [9:0]  inst_pc;
  logic        inst_vld;
  logic        inst_rdy;
  logic [9:0]  fetch_pc;
`ifdef AXIS_CPU_FETCH_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] inst_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [9:0] target;
    logic [7:0] rdy_pat;
    int         n;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .prog_wr_en_i  (prog_wr_en),
    .prog_wr_addr_i(prog_wr_addr),
    .prog_wr_data_i(prog_wr_data),
    .run_i         (run),
    .redirect_vld_i(redirect_vld),
    .redirect_pc_i (redirect_pc),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_vld_o    (inst_vld),
    .inst_rdy_i    (inst_rdy),
    .fetch_pc_o    (fetch_pc)
`ifdef AXIS_CPU_FETCH_STATS_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .inst_cnt_o    (inst_cnt)
`endif
  );

  function automatic logic [15:0] mdata(input logic [9:0] a);
    if (a < 10'd4) return 16'h1000 + {6'd0, a};
    return ({6'd0, a} * 16'd37) ^ 16'hC3A5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic take(input string name);
    logic [9:0] pc;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got pc %h want none (scoreboard empty)", name, inst_pc);
    end else begin
      pc = exp_q.pop_front();
      check({name, "_pc"}, 32'(inst_pc), 32'(pc));
      check({name, "_inst"}, 32'(inst), 32'(mdata(pc)));
    end
  endtask

  task automatic expect_seq(input logic [9:0] start, input int n);
    logic [9:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 10'd1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; redirect_vld = 1'b0; inst_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_stream(input int n, input logic [7:0] pat);
    int got;
    got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      inst_rdy = pat[c % 8];
      if (inst_vld && inst_rdy) begin
        take("stream");
        got++;
      end
      tick();
    end
    inst_rdy = 1'b0;
    check("stream_count", 32'(got), 32'(n));
  endtask

  task automatic apply_redirect(input logic [9:0] target);
    inst_rdy = 1'b0; run = 1'b1;
    redirect_vld = 1'b1; redirect_pc = target;
    tick();
    redirect_vld = 1'b0;
    check("redir_fpc", 32'(fetch_pc), 32'(target));
    check("redir_vld_r1", 32'(inst_vld), 32'd0);
    tick();
    check("redir_vld_r2", 32'(inst_vld), 32'd0);
    tick();
    check("redir_vld_r3", 32'(inst_vld), 32'd1);
    check("redir_first_pc", 32'(inst_pc), 32'(target));
  endtask

  initial begin
    tbl[0] = '{target: 10'h3FE, rdy_pat: 8'hFF, n: 4};
    tbl[1] = '{target: 10'h010, rdy_pat: 8'hAA, n: 5};
    tbl[2] = '{target: 10'h3F0, rdy_pat: 8'h33, n: 5};
    tbl[3] = '{target: 10'h155, rdy_pat: 8'h01, n: 3};

    rst = 1'b1; run = 1'b0; redirect_vld = 1'b0; redirect_pc = '0; inst_rdy = 1'b0;
    prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;
    tick();
    prog_wr_en = 1'b1;
    for (int a = 0; a < 1024; a++) begin
      prog_wr_addr = 10'(a);
      prog_wr_data = mdata(10'(a));
      tick();
    end
    prog_wr_en = 1'b0;

    // Reset state
    do_reset();
    check("rst_vld", 32'(inst_vld), 32'd0);
    check("rst_fpc", 32'(fetch_pc), 32'd0);
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_inst_pc", 32'(inst_pc), 32'd0);

    // Basic stream, then redirect while pc5 is in flight
    expect_seq(10'd0, 5);
    run = 1'b1; inst_rdy = 1'b1;
    tick();
    check("basic_lat_vld", 32'(inst_vld), 32'd0);
    check("basic_fpc1", 32'(fetch_pc), 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("basic_vld", 32'(inst_vld), 32'd1);
      if (k == 4) begin
        redirect_vld = 1'b1;
        redirect_pc  = 10'h3F0;
      end
      take("basic");
      tick();
    end
    redirect_vld = 1'b0;
    inst_rdy = 1'b0;
    check("inflight_vld_r1", 32'(inst_vld), 32'd0);
    check("inflight_fpc", 32'(fetch_pc), 32'h3F0);
    tick();
    check("inflight_vld_r2", 32'(inst_vld), 32'd0);
    tick();
    check("inflight_vld_r3", 32'(inst_vld), 32'd1);
    expect_seq(10'h3F0, 3);
    run_stream(3, 8'hFF);

    // Backpressure
    do_reset();
    run = 1'b1; inst_rdy = 1'b0;
    repeat (5) tick();
    check("bp_fpc", 32'(fetch_pc), 32'd2);
    check("bp_vld", 32'(inst_vld), 32'd1);
    check("bp_head_pc", 32'(inst_pc), 32'd0);
    expect_seq(10'd0, 6);
    run_stream(6, 8'hFF);

    // Redirect vectors: wrap and assorted ready patterns
    for (int v = 0; v < 4; v++) begin
      expect_seq(tbl[v].target, tbl[v].n);
      apply_redirect(tbl[v].target);
      run_stream(tbl[v].n, tbl[v].rdy_pat);
    end

    // Reset together with redirect while the FIFO is full
    apply_redirect(10'h020);
    tick();
    check("full_fpc", 32'(fetch_pc), 32'h022);
    rst = 1'b1; redirect_vld = 1'b1; redirect_pc = 10'h100;
    tick();
    check("midrst_vld", 32'(inst_vld), 32'd0);
    check("midrst_fpc", 32'(fetch_pc), 32'd0);
    check("midrst_inst_pc", 32'(inst_pc), 32'd0);
    rst = 1'b0; redirect_vld = 1'b0; run = 1'b1; inst_rdy = 1'b1;
    tick();
    check("restart_vld_r1", 32'(inst_vld), 32'd0);
    tick();
    check("restart_vld_r2", 32'(inst_vld), 32'd1);
    check("restart_pc", 32'(inst_pc), 32'd0);
    check("restart_inst", 32'(inst), 32'(mdata(10'd0)));

`ifdef AXIS_CPU_FETCH_STATS_EN
    do_reset();
    check("stats_rst_stall", stall_cnt, 32'd0);
    check("stats_rst_inst", inst_cnt, 32'd0);
    run = 1'b1; inst_rdy = 1'b0;
    tick();
    tick();
    repeat (3) tick();
    inst_rdy = 1'b1;
    repeat (4) tick();
    check("stats_stall", stall_cnt, 32'd3);
    check("stats_inst", inst_cnt, 32'd4);
    inst_rdy = 1'b0; run = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
